serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial sequencer that time-multiplexes one external 1-bit full adder (x, y, c_in -> s, c_out) to add two WIDTH-bit operands, LSB first, one bit per clock.
- Operands and results move over valid/ready handshakes.
- Sits between a register-level requester and the shared full-adder cell. Trades WIDTH cycles of latency for a single adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  initial carry-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result bits
- c_out  output  1  final carry-out (unsigned overflow)
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
- busy  output  1  high in RUN or DONE
- fa_x  output  1  to full adder x
- fa_y  output  1  to full adder y
- fa_c  output  1  to full adder carry-in
- fa_s  input  1  from full adder sum (combinational)
- fa_co  input  1  from full adder carry-out (combinational)

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-high. While rst=1 the FSM is in IDLE and all internal registers are 0.
  - Reset values: in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0, busy=0, fa_x/fa_y/fa_c=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a into a_sh, b into b_sh, c_in into carry; clear bit counter cnt; go to RUN.
  - Operands are sampled only on that edge.
- RUN:
  - in_ready=0.
  - Combinationally drive fa_x=a_sh[0], fa_y=b_sh[0], fa_c=carry.
  - Each edge:
    - sum_sh <= {fa_s, sum_sh[WIDTH-1:1]}
    - a_sh and b_sh shift right by 1
    - carry <= fa_co
    - cnt <= cnt+1
  - On the edge where cnt==WIDTH-1 (the MSB step):
    - capture prev_carry <= carry (carry into MSB)
    - capture c_out <= fa_co
    - ovf <= carry XOR fa_co
    - go to DONE
  - Exactly WIDTH cycles are spent in RUN.
  - cnt width is $clog2(WIDTH+1).
- DONE:
  - out_valid=1; sum, c_out and ovf are stable.
  - On an edge with out_ready=1, go to IDLE.
  - in_ready stays 0 in DONE, so in_valid is ignored, including when it coincides with out_ready. The next operand is accepted at the earliest one cycle after the result is consumed.
- fa_x/fa_y/fa_c: 0 in IDLE and DONE (adder idle).
- sum/c_out/ovf hold their last value after leaving DONE until the next result overwrites them.
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge. Throughput: one add per WIDTH+2 cycles when out_ready is held high.
- Arithmetic: {c_out, sum} = a + b + c_in, modulo 2^(WIDTH+1).
- WIDTH=1: a single RUN cycle. ovf = c_in XOR c_out.
- Reset mid-RUN or mid-DONE:
  - abort immediately (asynchronous) to IDLE with reset values;
  - the partial result is discarded;
  - no out_valid pulse after reset release.

Test Plan:
- WIDTH=8, a=0x0F, b=0x01, c_in=0, out_ready=1 -> out_valid exactly 8 edges after accept; sum=0x10, c_out=0, ovf=0; fa_x sequence LSB first = 1,1,1,1,0,0,0,0.
- a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, c_out=0, ovf=1.
- a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1, ovf=0. a=0x80, b=0x80, c_in=0 -> sum=0x00, c_out=1, ovf=1.
- Backpressure with a=0x12, b=0x34:
  - out_ready=0 for 5 cycles in DONE -> out_valid held, sum=0x46 stable, in_ready=0;
  - in_valid pulsed with a=0x01 during DONE is ignored;
  - after out_ready=1, next accept no earlier than the following cycle.
- Assert rst for one cycle after 3 RUN cycles of a=0xAA, b=0x55 -> in_ready=1 immediately, busy=0, no out_valid. A new request a=0x01, b=0x02 then yields sum=0x03.
- Random a, b, c_in (>=1000 transactions, random out_ready/in_valid gaps) -> {c_out, sum} matches the reference sum and ovf matches the signed-overflow model every transaction.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - operand and result handshake bundle for serial_add_ctrl
// Operand channel : in_valid, in_ready, a, b, c_in
// Result channel  : out_valid, out_ready, sum, c_out, ovf
// master = requester side, slave = serial_add_ctrl side
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer driving one shared full-adder cell
// clk, rst     : clock, asynchronous active-high reset
// bus (slave)  : operand request (in_*, a, b, c_in) and result (out_*, sum, c_out, ovf)
// busy         : high while an add is in progress or its result is waiting
// fa_x/y/c     : operand bits and carry to the external full adder (0 when idle)
// fa_s/fa_co   : combinational sum and carry back from the full adder
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_add_ctrl_if.slave    bus,
    output logic                busy,
    output logic                fa_x,
    output logic                fa_y,
    output logic                fa_c,
    input  logic                fa_s,
    input  logic                fa_co
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             prev_carry_q, prev_carry_d;
    logic             c_out_q, c_out_d;

    // Shift register contents after this cycle's adder bit enters at the MSB.
    logic [WIDTH-1:0] sum_next;

    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_next = fa_s;
        end else begin : g_wn
            assign sum_next = {fa_s, sum_sh_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        sum_sh_d     = sum_sh_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        cnt_d        = cnt_q;
        prev_carry_d = prev_carry_q;
        c_out_d      = c_out_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.c_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_sh_d = sum_next;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_co;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // MSB step: publish the result in one go so the visible
                    // sum never shows a half-shifted value.
                    prev_carry_d = carry_q;
                    c_out_d      = fa_co;
                    sum_d        = sum_next;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            sum_sh_q     <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            cnt_q        <= '0;
            prev_carry_q <= 1'b0;
            c_out_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            sum_sh_q     <= sum_sh_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            cnt_q        <= cnt_d;
            prev_carry_q <= prev_carry_d;
            c_out_q      <= c_out_d;
        end
    end

    wire run = (state_q == RUN);

    assign fa_x = run & a_sh_q[0];
    assign fa_y = run & b_sh_q[0];
    assign fa_c = run & carry_q;

    assign busy          = (state_q == RUN) || (state_q == DONE);
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign bus.ovf       = prev_carry_q ^ c_out_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl with a behavioural full adder
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, fa_x, fa_y, fa_c, fa_s, fa_co;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .fa_x  (fa_x),
        .fa_y  (fa_y),
        .fa_c  (fa_c),
        .fa_s  (fa_s),
        .fa_co (fa_co)
    );

    // Shared full-adder cell
    assign fa_s  = fa_x ^ fa_y ^ fa_c;
    assign fa_co = (fa_x & fa_y) | (fa_x & fa_c) | (fa_y & fa_c);

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit rand_mode = 1'b0;
    logic [9:0] exp_q[$];   // {c_out, ovf, sum}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a result transfers on the edge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got sum 0x%0h with no expected entry", bus.sum);
            end else begin
                chk("result{c_out,ovf,sum}", {22'd0, bus.c_out, bus.ovf, bus.sum}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    // Random consumer backpressure
    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Presents an operand at posedge+1 and returns at posedge+1 after it is accepted.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input bit push, input logic [W-1:0] es, input logic ec, input logic eo);
        int w;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.c_in = c;
        w = 0;
        while (!bus.in_ready && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", w);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (push) exp_q.push_back({ec, eo, es});
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        logic [W-1:0] fx;
        logic [W-1:0] ra, rb, rs;
        logic rc, ro, rco;
        logic [W:0] full;
        int n;
        bit seen;

        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.c_in = 1'b0;
        bus.out_ready = 1'b1;

        #2;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_sum_cout_ovf", {bus.c_out, bus.ovf, bus.sum}, 0);
        chk("reset_busy_fa", {busy, fa_x, fa_y, fa_c}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency and LSB-first operand bits on fa_x
        issue(8'h0F, 8'h01, 1'b0, 1, 8'h10, 1'b0, 1'b0);
        fx = '0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            if (n < W) fx[n] = fa_x;
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency_edges", n, W);
        chk("fa_x_sequence", fx, 8'h0F);
        chk("busy_in_done", busy, 1);

        issue(8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1, 1'b0);
        issue(8'h7F, 8'h01, 1'b0, 1, 8'h80, 1'b0, 1'b1);
        issue(8'hFF, 8'hFF, 1'b1, 1, 8'hFF, 1'b1, 1'b0);
        issue(8'h80, 8'h80, 1'b0, 1, 8'h00, 1'b1, 1'b1);
        wait_valid(n);
        @(posedge clk);
        #1;

        // Backpressure, with an operand offered during DONE
        bus.out_ready = 1'b0;
        issue(8'h12, 8'h34, 1'b0, 1, 8'h46, 1'b0, 1'b0);
        wait_valid(n);
        chk("bp_latency_edges", n, W);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid_held", bus.out_valid, 1);
            chk("bp_sum_stable", bus.sum, 8'h46);
            chk("bp_in_ready_low", bus.in_ready, 0);
            if (i == 2) begin
                bus.in_valid = 1'b1;
                bus.a = 8'h01;
                bus.b = 8'h00;
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_after_consume_idle", {bus.in_ready, bus.out_valid, busy}, 3'b100);
        chk("bp_result_held", bus.sum, 8'h46);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_ignored_operand", {bus.in_ready, busy}, 2'b10);

        // Reset after three RUN cycles
        issue(8'hAA, 8'h55, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_run_in_ready", bus.in_ready, 1);
        chk("rst_mid_run_busy", busy, 0);
        chk("rst_mid_run_out", {bus.out_valid, bus.c_out, bus.ovf, bus.sum}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("rst_no_out_valid", seen, 0);
        issue(8'h01, 8'h02, 1'b0, 1, 8'h03, 1'b0, 1'b0);
        wait_valid(n);
        chk("post_rst_latency", n, W);
        @(posedge clk);
        #1;

        // Random traffic
        rand_mode = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            rs = full[W-1:0];
            rco = full[W];
            ro = (ra[W-1] == rb[W-1]) && (rs[W-1] != ra[W-1]);
            issue(ra, rb, rc, 1, rs, rco, ro);
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
